// File: rtl/operand_stage.sv
// Operand fetch stage: reads the regfile, forwards from EX/WB, stalls on load-use
// hazards and registers a one-entry operand bundle for EX.

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module operand_stage #(
   parameter int unsigned AW = `REG_ADDR_WIDTH,
   parameter int unsigned DW = `REG_DATA_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_rs0,
   input  logic [AW-1:0] in_rs1,
   input  logic          in_use0,
   input  logic          in_use1,
   input  logic [AW-1:0] in_rd,
   input  logic          in_rd_we,
   output logic [AW-1:0] rf_r0addr,
   output logic [AW-1:0] rf_r1addr,
   input  logic [DW-1:0] rf_r0data,
   input  logic [DW-1:0] rf_r1data,
   input  logic          ex_fwd_valid,
   input  logic [AW-1:0] ex_fwd_addr,
   input  logic [DW-1:0] ex_fwd_data,
   input  logic          ex_fwd_is_load,
   input  logic          wb_wena,
   input  logic [AW-1:0] wb_waddr,
   input  logic [DW-1:0] wb_wdata,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_op0,
   output logic [DW-1:0] out_op1,
   output logic [AW-1:0] out_rd,
   output logic          out_rd_we,
   output logic [15:0]   stall_cnt
);

   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] op0_q, op0_d;
   logic [DW-1:0] op1_q, op1_d;
   logic [AW-1:0] rd_q;
   logic          rd_we_q;
   logic [15:0]   stall_cnt_q, stall_cnt_d;
   logic          hazard;
   logic          capture;

   assign rf_r0addr = in_rs0;
   assign rf_r1addr = in_rs1;

   // Only a load in EX blocks; its data is not produced until after EX.
   always_comb begin
      hazard = 1'b0;
      if (in_valid && ex_fwd_valid && ex_fwd_is_load) begin
         hazard = (in_use0 && (ex_fwd_addr == in_rs0)) ||
                  (in_use1 && (ex_fwd_addr == in_rs1));
      end
   end

   assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
   assign capture  = in_valid && in_ready;

   always_comb begin
      op0_d = rf_r0data;
      if (in_use0) begin
         if (ex_fwd_valid && !ex_fwd_is_load && (ex_fwd_addr == in_rs0)) begin
            op0_d = ex_fwd_data;
         end else if (wb_wena && (wb_waddr == in_rs0)) begin
            op0_d = wb_wdata;
         end
      end
   end

   always_comb begin
      op1_d = rf_r1data;
      if (in_use1) begin
         if (ex_fwd_valid && !ex_fwd_is_load && (ex_fwd_addr == in_rs1)) begin
            op1_d = ex_fwd_data;
         end else if (wb_wena && (wb_waddr == in_rs1)) begin
            op1_d = wb_wdata;
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (capture) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hazard && !flush && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         op0_q       <= '0;
         op1_q       <= '0;
         rd_q        <= '0;
         rd_we_q     <= 1'b0;
         stall_cnt_q <= 16'd0;
      end else begin
         out_valid_q <= out_valid_d;
         stall_cnt_q <= stall_cnt_d;
         if (capture) begin
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            rd_q    <= in_rd;
            rd_we_q <= in_rd_we;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_op0   = op0_q;
   assign out_op1   = op1_q;
   assign out_rd    = rd_q;
   assign out_rd_we = rd_we_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: a cycle model predicts handshakes, expected
// bundles are queued at acceptance and compared while presented at the output.

module tb_operand_stage;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready;
   logic [AW-1:0] in_rs0, in_rs1, in_rd;
   logic          in_use0, in_use1, in_rd_we;
   logic [AW-1:0] rf_r0addr, rf_r1addr;
   logic [DW-1:0] rf_r0data, rf_r1data;
   logic          ex_fwd_valid, ex_fwd_is_load;
   logic [AW-1:0] ex_fwd_addr;
   logic [DW-1:0] ex_fwd_data;
   logic          wb_wena;
   logic [AW-1:0] wb_waddr;
   logic [DW-1:0] wb_wdata;
   logic          flush;
   logic          out_valid, out_ready;
   logic [DW-1:0] out_op0, out_op1;
   logic [AW-1:0] out_rd;
   logic          out_rd_we;
   logic [15:0]   stall_cnt;

   typedef struct packed {
      logic [DW-1:0] op0;
      logic [DW-1:0] op1;
      logic [AW-1:0] rd;
      logic          we;
   } bundle_t;

   bundle_t       sb_q[$];
   logic          exp_valid;
   logic [15:0]   exp_stall;
   logic [DW-1:0] rf [32];
   int            n_checks = 0;
   int            n_errors = 0;

   always #5 clk = ~clk;

   assign rf_r0data = rf[rf_r0addr];
   assign rf_r1data = rf[rf_r1addr];

   operand_stage #(.AW(AW), .DW(DW)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_rs0         (in_rs0),
      .in_rs1         (in_rs1),
      .in_use0        (in_use0),
      .in_use1        (in_use1),
      .in_rd          (in_rd),
      .in_rd_we       (in_rd_we),
      .rf_r0addr      (rf_r0addr),
      .rf_r1addr      (rf_r1addr),
      .rf_r0data      (rf_r0data),
      .rf_r1data      (rf_r1data),
      .ex_fwd_valid   (ex_fwd_valid),
      .ex_fwd_addr    (ex_fwd_addr),
      .ex_fwd_data    (ex_fwd_data),
      .ex_fwd_is_load (ex_fwd_is_load),
      .wb_wena        (wb_wena),
      .wb_waddr       (wb_waddr),
      .wb_wdata       (wb_wdata),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_op0        (out_op0),
      .out_op1        (out_op1),
      .out_rd         (out_rd),
      .out_rd_we      (out_rd_we),
      .stall_cnt      (stall_cnt)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_op(input logic [AW-1:0] rs, input logic use_src);
      if (use_src && ex_fwd_valid && !ex_fwd_is_load && ex_fwd_addr == rs) return ex_fwd_data;
      if (use_src && wb_wena && wb_waddr == rs) return wb_wdata;
      return rf[rs];
   endfunction

   task automatic idle();
      in_valid = 0; in_rs0 = 0; in_rs1 = 0; in_use0 = 0; in_use1 = 0;
      in_rd = 0; in_rd_we = 0;
      ex_fwd_valid = 0; ex_fwd_addr = 0; ex_fwd_data = 0; ex_fwd_is_load = 0;
      wb_wena = 0; wb_waddr = 0; wb_wdata = 0;
      flush = 0; out_ready = 1;
   endtask

   task automatic instr(input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                        input logic u0, input logic u1,
                        input logic [AW-1:0] rd, input logic we);
      in_valid = 1; in_rs0 = rs0; in_rs1 = rs1; in_use0 = u0; in_use1 = u1;
      in_rd = rd; in_rd_we = we;
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic step(input string tag);
      logic    hz, rdy, cap;
      bundle_t b;
      #1;
      hz = in_valid && ex_fwd_valid && ex_fwd_is_load &&
           ((in_use0 && ex_fwd_addr == in_rs0) || (in_use1 && ex_fwd_addr == in_rs1));
      rdy = (!exp_valid || out_ready) && !hz && !flush;
      cap = in_valid && rdy;
      check_eq({tag, "_rdy"}, 64'(in_ready), 64'(rdy));
      check_eq({tag, "_raddr"}, 64'({rf_r0addr, rf_r1addr}), 64'({in_rs0, in_rs1}));
      b.op0 = model_op(in_rs0, in_use0);
      b.op1 = model_op(in_rs1, in_use1);
      b.rd  = in_rd;
      b.we  = in_rd_we;
      @(posedge clk);
      if (exp_valid && (out_ready || flush) && sb_q.size() > 0) void'(sb_q.pop_front());
      if (cap) sb_q.push_back(b);
      exp_valid = cap ? 1'b1 : ((flush || out_ready) ? 1'b0 : exp_valid);
      if (hz && !flush && exp_stall != 16'hFFFF) exp_stall++;
      #1;
      if (wb_wena) rf[wb_waddr] = wb_wdata;
      check_eq({tag, "_vld"}, 64'(out_valid), 64'(exp_valid));
      check_eq({tag, "_stall"}, 64'(stall_cnt), 64'(exp_stall));
      if (exp_valid) begin
         if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
         end else begin
            check_eq({tag, "_op0"}, 64'(out_op0), 64'(sb_q[0].op0));
            check_eq({tag, "_op1"}, 64'(out_op1), 64'(sb_q[0].op1));
            check_eq({tag, "_rd"}, 64'({out_rd, out_rd_we}), 64'({sb_q[0].rd, sb_q[0].we}));
         end
      end
      @(negedge clk);
   endtask

   // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
   task automatic do_reset();
      rst = 1;
      #1;
      check_eq("rst_vld", 64'(out_valid), 64'd0);
      check_eq("rst_op0", 64'(out_op0), 64'd0);
      check_eq("rst_op1", 64'(out_op1), 64'd0);
      check_eq("rst_rd", 64'({out_rd, out_rd_we}), 64'd0);
      check_eq("rst_stall", 64'(stall_cnt), 64'd0);
      sb_q.delete();
      exp_valid = 0;
      exp_stall = 0;
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
      idle();
      exp_valid = 0;
      exp_stall = 0;
      do_reset();

      // Plain regfile read of r3.
      rf[3] = 5;
      instr(3, 3, 1, 1, 7, 1);
      step("r19");
      check_eq("r19_ops", 64'({out_op0, out_op1}), {32'd5, 32'd5});

      // WB bypass in the capture cycle.
      wb_wena = 1; wb_waddr = 3; wb_wdata = 9;
      step("r20");
      check_eq("r20_op0", 64'(out_op0), 64'd9);

      // EX beats WB on the same register.
      ex_fwd_valid = 1; ex_fwd_addr = 3; ex_fwd_data = 7;
      step("r21");
      check_eq("r21_op0", 64'(out_op0), 64'd7);

      // Register 0 is an ordinary register.
      idle();
      rf[0] = 32'h1234;
      instr(0, 0, 1, 1, 0, 1);
      step("r0");
      check_eq("r0_op0", 64'(out_op0), 64'h1234);

      // Unused sources: no forwarding and no hazard.
      rf[1] = 11;
      instr(1, 1, 0, 0, 2, 0);
      ex_fwd_valid = 1; ex_fwd_addr = 1; ex_fwd_data = 32'hAAAA; ex_fwd_is_load = 0;
      step("unused_fwd");
      check_eq("unused_fwd_op0", 64'(out_op0), 64'd11);
      ex_fwd_is_load = 1;
      #1 check_eq("unused_ld_rdy", 64'(in_ready), 64'd1);
      step("unused_ld");

      // Load-use stall for two cycles, then release.
      idle();
      rf[2] = 22;
      instr(4, 2, 0, 1, 6, 1);
      ex_fwd_valid = 1; ex_fwd_addr = 2; ex_fwd_is_load = 1;
      step("r22a");
      step("r22b");
      check_eq("r22_vld", 64'(out_valid), 64'd0);
      check_eq("r22_stall", 64'(stall_cnt), 64'd2);
      ex_fwd_valid = 0;
      step("r22c");
      check_eq("r22_cap", 64'({out_valid, out_op1}), {31'd0, 1'b1, 32'd22});

      // Backpressure holds the bundle, then flush drops it.
      idle();
      step("r23_drain");
      rf[5] = 55;
      instr(5, 5, 1, 0, 9, 1);
      out_ready = 0;
      step("r23_cap");
      instr(6, 6, 1, 1, 3, 0);
      for (int i = 0; i < 3; i++) step("r23_hold");
      check_eq("r23_held", 64'({out_op0, out_rd, out_rd_we}), {27'd0, 32'd55, 5'd9, 1'b1});
      flush = 1;
      step("r23_flush");
      check_eq("r23_flush_vld", 64'(out_valid), 64'd0);

      // Reset mid-operation with a valid bundle and a non-zero stall count.
      idle();
      do_reset();
      instr(3, 0, 1, 0, 4, 1);
      out_ready = 0;
      step("r24_cap");
      ex_fwd_valid = 1; ex_fwd_addr = 3; ex_fwd_is_load = 1;
      for (int i = 0; i < 4; i++) step("r24_hz");
      check_eq("r24_pre", 64'({out_valid, stall_cnt}), 64'({1'b1, 16'd4}));
      #2;
      do_reset();
      idle();
      instr(3, 3, 1, 1, 1, 1);
      step("r18_first");

      // Randomised traffic with a small register range to force collisions.
      for (int i = 0; i < 60; i++) begin
         in_valid       = ($urandom_range(3) != 0);
         in_rs0         = AW'($urandom_range(3));
         in_rs1         = AW'($urandom_range(3));
         in_use0        = 1'($urandom);
         in_use1        = 1'($urandom);
         in_rd          = AW'($urandom);
         in_rd_we       = 1'($urandom);
         ex_fwd_valid   = 1'($urandom);
         ex_fwd_addr    = AW'($urandom_range(3));
         ex_fwd_data    = $urandom;
         ex_fwd_is_load = ($urandom_range(3) == 0);
         wb_wena        = 1'($urandom);
         wb_waddr       = AW'($urandom_range(3));
         wb_wdata       = $urandom;
         flush          = ($urandom_range(9) == 0);
         out_ready      = ($urandom_range(3) != 0);
         step("rnd");
      end

      idle();
      step("final");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter AW, default `REG_ADDR_WIDTH, register address width.
REQ-002 SHALL have parameter DW, default `REG_DATA_WIDTH, register data width.
REQ-003 SHALL have ports (name direction width meaning), clock and reset first:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs0, in_rs1  in  AW  source register addresses
- in_use0, in_use1  in  1  source actually read
- in_rd  in  AW  destination address
- in_rd_we  in  1  destination written
- rf_r0addr, rf_r1addr  out  AW  regfile read addresses (combinational)
- rf_r0data, rf_r1data  in  DW  regfile read data (combinational)
- ex_fwd_valid  in  1  EX stage holds a register-writing instruction
- ex_fwd_addr  in  AW  EX destination
- ex_fwd_data  in  DW  EX ALU result
- ex_fwd_is_load  in  1  EX instruction is a load; data not yet available
- wb_wena, wb_waddr, wb_wdata  in  1/AW/DW  regfile write port this cycle
- flush  in  1  kill captured and incoming instruction
- out_valid  out  1  operand bundle valid
- out_ready  in  1  EX accepts bundle
- out_op0, out_op1  out  DW  resolved operands
- out_rd, out_rd_we  out  AW/1  registered destination fields
- stall_cnt  out  16  load-use stall cycles, debug probe

Function
REQ-004 SHALL drive rf_r0addr=in_rs0 and rf_r1addr=in_rs1 combinationally.
REQ-005 SHALL resolve each used operand with priority: EX match (ex_fwd_valid, ex_fwd_addr==rs, !ex_fwd_is_load) > WB match (wb_wena, wb_waddr==rs) > regfile data.
REQ-006 SHALL treat every address, including 0, as a normal register; no hardwired zero.
REQ-007 SHALL assert hazard when in_valid and a used source equals ex_fwd_addr while ex_fwd_valid and ex_fwd_is_load.
REQ-008 SHALL set in_ready = (!out_valid | out_ready) & !hazard & !flush.
REQ-009 SHALL capture operands, in_rd, in_rd_we into output registers and set out_valid=1 on the edge where in_valid & in_ready.
REQ-010 SHALL clear out_valid when out_ready=1 and no capture occurs (bubble insertion during hazard).
REQ-011 SHALL hold all output registers unchanged while out_valid & !out_ready.
REQ-012 SHALL clear out_valid on any edge with flush=1, regardless of out_ready; no capture that cycle.
REQ-013 SHALL report unused-source operands as the regfile value without forwarding or hazard contribution.
REQ-014 SHALL increment stall_cnt on each edge where in_valid & hazard & !flush, saturating at 16'hFFFF.
REQ-015 SHALL have one-cycle latency: accepted instruction appears at out_* on the following cycle.
REQ-016 SHALL resolve simultaneous EX and WB matches to the same register with EX data.

Reset
REQ-017 SHALL, on rst high, asynchronously set out_valid=0, out_op0=0, out_op1=0, out_rd=0, out_rd_we=0, stall_cnt=0.
REQ-018 SHALL drop any in-flight bundle on reset mid-operation; first capture occurs on the first edge after rst deasserts.

Verification
REQ-019 Regfile r3=5, in rs0=3 rs1=3 use both, no fwd -> next cycle out_valid=1, op0=op1=5.
REQ-020 r3=5, wb_wena waddr=3 wdata=9 same cycle as capture -> op0=9.
REQ-021 EX fwd addr=3 data=7 non-load plus WB addr=3 data=9 -> op0=7.
REQ-022 EX load to r2, in rs1=2 use1=1 for 2 cycles -> in_ready=0, out_valid=0 after drain, stall_cnt=2; load clears -> capture next edge.
REQ-023 out_valid=1, out_ready=0 for 3 cycles with new in_valid -> outputs stable, in_ready=0; flush asserted -> out_valid=0 next cycle.
REQ-024 Assert rst while out_valid=1, stall_cnt=4 -> immediately out_valid=0, stall_cnt=0 before next edge.
